// File: rtl/regfile_bank_pkg.sv
// Shared definitions for the regfile_bank register file.
//   scrub_state_e : scrub controller FSM encoding (S_SCRUB / S_READY)
//   DEF_DATA_W    : default register width
//   DEF_ADDR_W    : default address width (DEPTH = 2**ADDR_W)
//   REG_*         : MIPS register index constants
package regfile_bank_pkg;

  typedef enum logic {
    S_SCRUB = 1'b0,
    S_READY = 1'b1
  } scrub_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;
  localparam int REG_A0   = 4;
  localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_bank_scrub_ctrl.sv
// Reset scrub controller for regfile_bank.
// When SCRUB=1 a synchronous reset parks the FSM in S_SCRUB with cnt=0; each
// following posedge clears entry cnt and advances. The edge that clears entry
// DEPTH-1 moves the FSM to S_READY, so busy is high for exactly DEPTH cycles.
// When SCRUB=0 reset goes straight to S_READY (the top clears the array itself).
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   busy        : 1 while scrubbing
//   scrub_we    : clear strobe for the array
//   scrub_addr  : entry being cleared
//   state_o     : current FSM state
module regfile_bank_scrub_ctrl
  import regfile_bank_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter bit SCRUB  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              scrub_we,
  output logic [ADDR_W-1:0] scrub_addr,
  output scrub_state_e      state_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst) begin
      state_d = SCRUB ? S_SCRUB : S_READY;
      cnt_d   = '0;
    end else if (state_q == S_SCRUB) begin
      // Counter stops at the last entry instead of wrapping.
      if (cnt_q == LAST_ADDR) begin
        state_d = S_READY;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

  assign busy       = (state_q == S_SCRUB);
  assign scrub_we   = (state_q == S_SCRUB) && !rst;
  assign scrub_addr = cnt_q;
  assign state_o    = state_q;

endmodule

// File: rtl/regfile_bank.sv
// Parametrised MIPS general-purpose register file.
// Two combinational read ports (rs/rt) with optional same-cycle write bypass
// and a hardwired zero register, one write port, a handshaked debug read port
// and two registered watch taps. The array has a single write port (scrub or
// port write) so it can map to RAM when SCRUB=1.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   rs_addr/rs_data        : read port A (combinational)
//   rt_addr/rt_data        : read port B (combinational)
//   we/wr_addr/wr_data     : write port
//   busy                   : scrub in progress; writes/debug dropped, reads 0
//   dbg_req/dbg_addr       : debug read request (one-cycle pulse per read)
//   dbg_valid/dbg_data     : debug response, one cycle after request;
//                            dbg_data holds until the next accepted request
//   watch0/watch1          : registered copies of entries WATCH0_IDX/WATCH1_IDX
// Debug handshake: a request is accepted on any posedge where dbg_req=1, the
// FSM is in S_READY and rst=0; the response (pre-edge array value, never
// bypassed) appears with dbg_valid=1 for exactly the following cycle.
module regfile_bank
  import regfile_bank_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1,
  parameter bit SCRUB      = 1'b1,
  parameter int WATCH0_IDX = REG_V0,
  parameter int WATCH1_IDX = REG_A0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_valid,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] watch0,
  output logic [DATA_W-1:0] watch1
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] W0_ADDR   = ADDR_W'(WATCH0_IDX);
  localparam logic [ADDR_W-1:0] W1_ADDR   = ADDR_W'(WATCH1_IDX);

  scrub_state_e      scrub_state;
  logic              scrub_we;
  logic [ADDR_W-1:0] scrub_addr;

  regfile_bank_scrub_ctrl #(
    .ADDR_W (ADDR_W),
    .SCRUB  (SCRUB)
  ) u_scrub_ctrl (
    .clk        (clk),
    .rst        (rst),
    .busy       (busy),
    .scrub_we   (scrub_we),
    .scrub_addr (scrub_addr),
    .state_o    (scrub_state)
  );

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              ready;
  logic              port_we;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_data;

  assign ready = (scrub_state == S_READY) && !rst;

  // A write to the zero register is suppressed entirely, including bypass.
  assign port_we = ready && we && !(ZERO_REG && (wr_addr == ZERO_ADDR));

  always_comb begin
    arr_we   = port_we;
    arr_addr = wr_addr;
    arr_data = wr_data;
    if (scrub_we) begin
      arr_we   = 1'b1;
      arr_addr = scrub_addr;
      arr_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!SCRUB && rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (arr_we) begin
      mem_q[arr_addr] <= arr_data;
    end
  end

  // Array contents as seen by readers, with the zero register forced to 0.
  function automatic logic [DATA_W-1:0] stored_val(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] word);
    if (ZERO_REG && (a == ZERO_ADDR)) return '0;
    return word;
  endfunction

  // Value an entry will hold after this edge (port write applied).
  function automatic logic [DATA_W-1:0] post_write(input logic [ADDR_W-1:0] a,
                                                   input logic [DATA_W-1:0] word);
    if (port_we && (wr_addr == a)) return wr_data;
    return stored_val(a, word);
  endfunction

  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (!busy) begin
      rs_data = stored_val(rs_addr, mem_q[rs_addr]);
      rt_data = stored_val(rt_addr, mem_q[rt_addr]);
      if (BYPASS && port_we && (wr_addr == rs_addr)) rs_data = wr_data;
      if (BYPASS && port_we && (wr_addr == rt_addr)) rt_data = wr_data;
    end
  end

  logic              dbg_valid_q, dbg_valid_d;
  logic [DATA_W-1:0] dbg_data_q,  dbg_data_d;
  logic [DATA_W-1:0] watch0_q,    watch0_d;
  logic [DATA_W-1:0] watch1_q,    watch1_d;

  always_comb begin
    dbg_valid_d = 1'b0;
    dbg_data_d  = dbg_data_q;
    watch0_d    = '0;
    watch1_d    = '0;
    if (rst) begin
      dbg_data_d = '0;
    end else if (ready) begin
      if (dbg_req) begin
        dbg_valid_d = 1'b1;
        dbg_data_d  = stored_val(dbg_addr, mem_q[dbg_addr]);
      end
      watch0_d = post_write(W0_ADDR, mem_q[W0_ADDR]);
      watch1_d = post_write(W1_ADDR, mem_q[W1_ADDR]);
    end
  end

  always_ff @(posedge clk) begin
    dbg_valid_q <= dbg_valid_d;
    dbg_data_q  <= dbg_data_d;
    watch0_q    <= watch0_d;
    watch1_q    <= watch1_d;
  end

  assign dbg_valid = dbg_valid_q;
  assign dbg_data  = dbg_data_q;
  assign watch0    = watch0_q;
  assign watch1    = watch1_q;

endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: a default instance (32x32, scrub reset)
// and a small instance (8x16, reset clears at the edge, no zero register).
module tb_regfile_bank;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, wr_addr, dbg_addr;
  logic [31:0] rs_data, rt_data, wr_data, dbg_data, watch0, watch1;
  logic        we, busy, dbg_req, dbg_valid;

  logic        rst_b;
  logic [2:0]  rs_addr_b, rt_addr_b, wr_addr_b, dbg_addr_b;
  logic [15:0] rs_data_b, rt_data_b, wr_data_b, dbg_data_b, watch0_b, watch1_b;
  logic        we_b, busy_b, dbg_req_b, dbg_valid_b;

  int tests;
  int fails;
  int n;
  logic seen_valid;

  regfile_bank dut (
    .clk       (clk),
    .rst       (rst),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_valid (dbg_valid),
    .dbg_data  (dbg_data),
    .watch0    (watch0),
    .watch1    (watch1)
  );

  regfile_bank #(
    .DATA_W   (16),
    .ADDR_W   (3),
    .ZERO_REG (1'b0),
    .SCRUB    (1'b0)
  ) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .rs_addr   (rs_addr_b),
    .rt_addr   (rt_addr_b),
    .rs_data   (rs_data_b),
    .rt_data   (rt_data_b),
    .we        (we_b),
    .wr_addr   (wr_addr_b),
    .wr_data   (wr_data_b),
    .busy      (busy_b),
    .dbg_req   (dbg_req_b),
    .dbg_addr  (dbg_addr_b),
    .dbg_valid (dbg_valid_b),
    .dbg_data  (dbg_data_b),
    .watch0    (watch0_b),
    .watch1    (watch1_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0;
    rs_addr = '0; rt_addr = '0; dbg_req = 1'b0; dbg_addr = '0;
    rst_b = 1'b1; we_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    rs_addr_b = '0; rt_addr_b = '0; dbg_req_b = 1'b0; dbg_addr_b = '0;

    // Reset state and scrub length
    tick();
    rst = 1'b0;
    check("rst_dbg_valid", 32'(dbg_valid), 32'd0);
    check("rst_dbg_data", dbg_data, 32'd0);
    check("rst_watch0", watch0, 32'd0);
    check("rst_watch1", watch1, 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("scrub_len", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      check("scrub_rs_zero", rs_data, 32'd0);
      check("scrub_rt_zero", rt_data, 32'd0);
    end

    // Bypass and watch0
    tick();
    we = 1'b1; wr_addr = 5'd2; wr_data = 32'hDEADBEEF; rs_addr = 5'd2;
    #1;
    check("bypass_rs", rs_data, 32'hDEADBEEF);
    tick();
    we = 1'b0;
    #1;
    check("watch0_after_wr", watch0, 32'hDEADBEEF);
    check("rs_stored", rs_data, 32'hDEADBEEF);

    // Zero register
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; rs_addr = 5'd0; rt_addr = 5'd0;
    #1;
    check("zero_rs_same", rs_data, 32'd0);
    check("zero_rt_same", rt_data, 32'd0);
    tick();
    we = 1'b0;
    #1;
    check("zero_rs_after", rs_data, 32'd0);

    // rt bypass, no bypass on other port; also write entry 20
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'h55; rt_addr = 5'd5; rs_addr = 5'd6;
    #1;
    check("bypass_rt", rt_data, 32'h55);
    check("no_bypass_rs", rs_data, 32'd0);
    tick();
    wr_addr = 5'd20; wr_data = 32'hAB;
    tick();

    // Debug returns pre-edge value; watch1 post-write; back-to-back requests
    wr_addr = 5'd4; wr_data = 32'h11;
    tick();
    check("watch1_first", watch1, 32'h11);
    wr_data = 32'h22; dbg_req = 1'b1; dbg_addr = 5'd4;
    tick();
    we = 1'b0; dbg_addr = 5'd2;
    check("dbg_valid_1", 32'(dbg_valid), 32'd1);
    check("dbg_data_pre", dbg_data, 32'h11);
    check("watch1_second", watch1, 32'h22);
    tick();
    dbg_req = 1'b0;
    check("dbg_valid_b2b", 32'(dbg_valid), 32'd1);
    check("dbg_data_b2b", dbg_data, 32'hDEADBEEF);
    tick();
    check("dbg_valid_drop", 32'(dbg_valid), 32'd0);
    check("dbg_data_hold", dbg_data, 32'hDEADBEEF);
    rs_addr = 5'd20;
    #1;
    check("rs_entry20", rs_data, 32'hAB);

    // Reset in the middle of a scrub
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy", 32'(busy), 32'd1);
    rs_addr = 5'd20;
    #1;
    check("busy_read_zero", rs_data, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    we = 1'b1; wr_addr = 5'd2; wr_data = 32'h99; dbg_req = 1'b1; dbg_addr = 5'd2;
    n = 0;
    seen_valid = 1'b0;
    while (busy && n < 100) begin
      tick();
      n++;
      if (dbg_valid) seen_valid = 1'b1;
      if (!busy) begin
        we = 1'b0;
        dbg_req = 1'b0;
      end
    end
    we = 1'b0; dbg_req = 1'b0;
    check("restart_len", 32'(n), 32'd32);
    check("scrub_no_dbg", 32'(seen_valid), 32'd0);
    rs_addr = 5'd2;
    rt_addr = 5'd20;
    #1;
    check("scrub_dropped_wr", rs_data, 32'd0);
    check("scrub_cleared_20", rt_data, 32'd0);
    check("scrub_watch0", watch0, 32'd0);
    check("scrub_dbg_valid", 32'(dbg_valid), 32'd0);

    // Small instance: reset clears at the edge
    tick();
    rst_b = 1'b0;
    check("b_busy", 32'(busy_b), 32'd0);
    for (int i = 0; i < 8; i++) begin
      we_b = 1'b1; wr_addr_b = 3'(i); wr_data_b = 16'(i) ^ 16'hA5A5;
      tick();
    end
    we_b = 1'b0;
    #1;
    check("b_watch0", 32'(watch0_b), 32'h0000A5A7);
    check("b_watch1", 32'(watch1_b), 32'h0000A5A1);
    for (int i = 0; i < 8; i++) begin
      rs_addr_b = 3'(i);
      rt_addr_b = 3'(7 - i);
      #1;
      check("b_rs_read", 32'(rs_data_b), 32'(16'(i) ^ 16'hA5A5));
      check("b_rt_read", 32'(rt_data_b), 32'(16'(7 - i) ^ 16'hA5A5));
    end
    tick();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    check("b_rst_busy", 32'(busy_b), 32'd0);
    check("b_rst_watch0", 32'(watch0_b), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rs_addr_b = 3'(i);
      #1;
      check("b_rst_clear", 32'(rs_data_b), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
